// File: rtl/mul_pkg.sv
// mul_pkg: shared types and helpers for the sequential RV32M multiplier.
//   mul_op_e    : operation encoding (matches the 2-bit op input)
//   mul_state_e : control FSM states
//   XLEN        : operand width
//   op_a_signed / op_b_signed : whether rs1 / rs2 are treated as signed
package mul_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // MUL returns the low word, which does not depend on signedness, so it
  // is handled as unsigned.
  function automatic logic op_a_signed(input mul_op_e op);
    return (op == MULH) || (op == MULHSU);
  endfunction

  function automatic logic op_b_signed(input mul_op_e op);
    return (op == MULH);
  endfunction

endpackage

// File: rtl/mul_seq_32_add_32.sv
// full_adder: single-bit full adder cell.
// add_32: 32-bit ripple-carry adder built from full_adder cells.
//   a, b  : 32-bit addends
//   cin   : carry in
//   s     : 32-bit sum
//   c_out : carry out of bit 31
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module add_32
  import mul_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cin,
  output logic [XLEN-1:0] s,
  output logic            c_out
);
  logic [XLEN:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < XLEN; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign c_out = c[XLEN];
endmodule

// File: rtl/mul_seq_32.sv
// mul_seq_32: multi-cycle radix-2 shift-add multiplier for RV32M
// MUL / MULH / MULHSU / MULHU. Operands are reduced to magnitudes,
// multiplied unsigned one bit per cycle, then conditionally negated.
//
// Ports:
//   clk    : core clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request, sampled only in IDLE
//   op     : 0=MUL, 1=MULH, 2=MULHSU, 3=MULHU
//   a, b   : rs1 / rs2 operands, captured on accepted start
//   busy   : high in CALC and DONE
//   done   : one-cycle pulse when result is valid
//   result : selected product word, held until replaced by the next op
//
// Build option MUL_EARLY_TERM_EN: when defined, CALC ends as soon as the
// remaining multiplier bits are zero, applying the leftover shifts in one
// cycle. Results are identical either way; only latency changes.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one add/shift iteration per cycle
// DONE  | result valid, done pulsed
module mul_seq_32
  import mul_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mul_state_e      state;
  mul_op_e         op_q;
  logic [64:0]     p;
  logic [XLEN-1:0] mcand;
  logic            neg;
  logic [CNT_W-1:0] cnt;

  // Operand conditioning at accept time.
  mul_op_e         op_in;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;

  assign op_in = mul_op_e'(op);
  assign a_neg = op_a_signed(op_in) && a[XLEN-1];
  assign b_neg = op_b_signed(op_in) && b[XLEN-1];
  // |0x80000000| wraps back to 0x80000000, which is correct as unsigned.
  assign mag_a = a_neg ? (~a + 1'b1) : a;
  assign mag_b = b_neg ? (~b + 1'b1) : b;

  // One iteration: conditional add into the upper half, then shift right.
  logic [XLEN-1:0] add_s;
  logic            add_c;
  logic [XLEN:0]   sum_hi;
  logic [64:0]     p_step;
  logic [CNT_W-1:0] cnt_next;
  logic [64:0]     p_fin;
  logic            calc_last;
  logic [63:0]     prod;

  add_32 u_add (
    .a     (p[63:32]),
    .b     (mcand),
    .cin   (1'b0),
    .s     (add_s),
    .c_out (add_c)
  );

  assign sum_hi   = p[0] ? {add_c, add_s} : p[64:32];
  assign p_step   = {1'b0, sum_hi, p[31:1]};
  assign cnt_next = cnt + 1'b1;

`ifdef MUL_EARLY_TERM_EN
  // After this cycle's shift, the unconsumed multiplier bits sit in
  // p_step[31-cnt_next:0]. Once those are zero, every remaining iteration
  // is a pure shift, so they collapse into a single barrel shift.
  logic [XLEN-1:0] rem_mask;
  assign rem_mask  = 32'hFFFF_FFFF >> cnt_next;
  assign calc_last = ((p_step[31:0] & rem_mask) == '0);
  assign p_fin     = p_step >> (CNT_W'(XLEN) - cnt_next);
`else
  assign calc_last = (cnt_next == CNT_W'(XLEN));
  assign p_fin     = p_step;
`endif

  assign prod = neg ? (~p_fin[63:0] + 64'd1) : p_fin[63:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= MUL;
      p      <= '0;
      mcand  <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= op_in;
            mcand <= mag_a;
            neg   <= a_neg ^ b_neg;
            p     <= {33'b0, mag_b};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt_next;
          if (calc_last) begin
            p      <= p_fin;
            result <= (op_q == MUL) ? prod[31:0] : prod[63:32];
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            p <= p_step;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mul_seq_32.md
Name: mul_seq_32

Overview:
Multi-cycle radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU. It is the additive counterpart of the datapath's 32-bit subtractor and sits beside the ALU in the execute stage. A start/busy/done handshake stalls the core while the product iterates. Operands are converted to magnitudes, multiplied unsigned, then conditionally negated.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
clk  input  1  core clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
op  input  2  0=MUL (low word), 1=MULH (s×s), 2=MULHSU (a signed × b unsigned), 3=MULHU (u×u).
a  input  32  rs1 operand, captured on accepted start.
b  input  32  rs2 operand, captured on accepted start.
busy  output  1  high in CALC and DONE.
done  output  1  one-cycle pulse when result is valid.
result  output  32  selected product word; held until the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0; internal registers cleared. Reset during CALC/DONE aborts the operation with no done pulse.
- States: IDLE -> CALC on start=1; CALC -> DONE after the final iteration; DONE -> IDLE unconditionally after 1 cycle.
- Accept (IDLE, start=1):
  - Latch op.
  - mcand = |a| if a is signed for op, else a.
  - mplier = |b| if b is signed for op, else b.
  - neg = sign(a)^sign(b), counting only operands that are signed for op.
  - |0x80000000| = 0x80000000, treated as unsigned.
  - P[64:0] = {33'b0, mplier}; cnt = 0.
- CALC, each cycle:
  - If P[0], then P[64:32] = P[63:32] + mcand, using a 33-bit sum with carry.
  - Then P is logically shifted right by 1; cnt++.
  - After 32 iterations, P[63:0] = unsigned product.
- Leaving CALC:
  - prod = neg ? (~P[63:0] + 1) : P[63:0], as a 64-bit two's-complement negate.
  - result = prod[31:0] for MUL, else prod[63:32]. It is registered on entry to DONE.
- Latency: start accepted at edge k; CALC spans 32 cycles; done=1 in the cycle after edge k+32. Fixed 33 cycles, independent of data.
- start while busy=1 is ignored; operands are not re-latched.
- start is level-sampled. start held high through DONE is re-accepted in the next IDLE cycle (back-to-back ops, 1 idle cycle between).
- MUL low word is identical for all sign modes; MUL is treated as unsigned (neg=0).
- The MSB carry into P[64] is never lost, because the add result is 33 bits.

Optional Feature:
MUL_EARLY_TERM_EN.
- Defined:
  - In CALC, if the unconsumed multiplier bits (P[31-cnt:0], i.e. P[31:0] >> ... equivalently the remaining low bits) are all zero, apply the remaining (32-cnt) right shifts in one cycle via a barrel shift and go to DONE.
  - CALC length = max(1, position of highest set bit of mplier + 1).
  - mplier=0 costs 1 CALC cycle.
- Undefined: fixed 32 CALC cycles; no barrel shifter is synthesized.
- Results are identical in both builds; only latency differs.

Decomposition:
- Package mul_pkg:
  - mul_op_e enum (MUL, MULH, MULHSU, MULHU).
  - mul_state_e enum (IDLE, CALC, DONE).
  - XLEN constant.
  - Function op_a_signed(op) and function op_b_signed(op).
- One sub-module: add_32, a 32-bit ripple adder (a, b, cin -> s, c_out) built from the existing full_adder cell. It is used for the partial-product add.
- Negation stays inline.

Test Plan:
- MUL a=7, b=6 -> busy rises the cycle after start; done pulses exactly 33 cycles after start accepted; result=0x0000002A.
- MULH a=0x80000000, b=0x80000000 -> result=0x40000000. MULH a=0xFFFFFFFF(-1), b=0x00000002 -> result=0xFFFFFFFF.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> product 0xFFFFFFFF_00000001, result=0xFFFFFFFF. MULHU same operands -> result=0xFFFFFFFE.
- Start pulsed at cycle 5 of CALC with a=1, b=1 -> ignored; first op's result unchanged; done count = 1.
- rst_n low at CALC cycle 10 -> busy=0, done=0, result=0 immediately (async); no done pulse afterward. Next op after release completes normally.
- MUL_EARLY_TERM_EN defined: MUL a=5, b=3 -> done 3 cycles after start (2 CALC + DONE), result=0x0000000F. b=0 -> done after 2 cycles, result=0. Same vectors without the macro -> 33 cycles, identical results.
